// File: rtl/m_branch_target_buffer_if.sv
// Bundle between the fetch stage, the branch-resolving stage and the BTB:
// the per-cycle lookup, the resolved-branch update, the invalidate strobe
// and the statistics read-back.
interface m_branch_target_buffer_if #(
    parameter int STAT_W = 32
);
    logic              lookup_valid;
    logic [31:0]       lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_mispredict;
    logic              invalidate;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_mispredicts;

    // BTB side
    modport slave (
        input  lookup_valid, lookup_pc,
        output pred_hit, pred_taken, pred_target,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  invalidate,
        output stat_lookups, stat_hits, stat_mispredicts
    );

    // Pipeline side
    modport master (
        output lookup_valid, lookup_pc,
        input  pred_hit, pred_taken, pred_target,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output invalidate,
        input  stat_lookups, stat_hits, stat_mispredicts
    );
endinterface

// File: rtl/m_branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and saturating lookup/hit/mispredict statistics. Storage is kept
// in flops so the whole table can be cleared by the asynchronous reset.
module m_branch_target_buffer #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 2,
    parameter int STAT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    m_branch_target_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + 2 + TAG_BITS - 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_WNT  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_WT   = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;
    localparam logic [STAT_W-1:0]   STAT_ONE = STAT_W'(1);

    // Table storage
    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [CNT_BITS-1:0] r_cnt    [ENTRIES];

    // Next-state of every entry
    logic [ENTRIES-1:0]  w_valid_next;
    logic [TAG_BITS-1:0] w_tag_next    [ENTRIES];
    logic [31:0]         w_target_next [ENTRIES];
    logic [CNT_BITS-1:0] w_cnt_next    [ENTRIES];

    logic [STAT_W-1:0] r_stat_lookups;
    logic [STAT_W-1:0] r_stat_hits;
    logic [STAT_W-1:0] r_stat_mispredicts;

    // Lookup path: purely combinational, reads registered contents only, so a
    // same-cycle update to the same index is not visible until the next cycle.
    logic [IDX_W-1:0]    w_lk_idx;
    logic [TAG_BITS-1:0] w_lk_tag;
    logic                w_lk_hit;

    assign w_lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign w_lk_tag = bus.lookup_pc[TAG_HI:TAG_LO];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign bus.pred_hit    = w_lk_hit;
    assign bus.pred_taken  = w_lk_hit && r_cnt[w_lk_idx][CNT_BITS-1];
    assign bus.pred_target = w_lk_hit ? r_target[w_lk_idx] : (bus.lookup_pc + 32'd4);

    // Update path decode; invalidate drops any simultaneous update.
    logic [IDX_W-1:0]    w_upd_idx;
    logic [TAG_BITS-1:0] w_upd_tag;
    logic                w_upd_hit;
    logic                w_upd_en;
    logic                w_inv;

    assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
    assign w_upd_tag = bus.upd_pc[TAG_HI:TAG_LO];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_inv     = ce && bus.invalidate;
    assign w_upd_en  = ce && bus.upd_valid && !bus.invalidate;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic w_sel;
            logic w_train;
            logic w_alloc;

            assign w_sel   = w_upd_en && (w_upd_idx == IDX_W'(gi));
            assign w_train = w_sel && w_upd_hit;
            assign w_alloc = w_sel && !w_upd_hit && bus.upd_taken;

            assign w_valid_next[gi]  = w_inv ? 1'b0 : (w_alloc ? 1'b1 : r_valid[gi]);
            assign w_tag_next[gi]    = w_alloc ? w_upd_tag : r_tag[gi];
            assign w_target_next[gi] = (w_alloc || (w_train && bus.upd_taken)) ?
                                       bus.upd_target : r_target[gi];
            assign w_cnt_next[gi] =
                w_alloc ? CNT_WT :
                !w_train ? r_cnt[gi] :
                bus.upd_taken ? ((r_cnt[gi] == CNT_MAX)  ? CNT_MAX  : r_cnt[gi] + CNT_ONE) :
                                ((r_cnt[gi] == CNT_ZERO) ? CNT_ZERO : r_cnt[gi] - CNT_ONE);
        end
    endgenerate

    // Table register: cleared to weakly-not-taken on reset, held when ce is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (ce) begin
            r_valid <= w_valid_next;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= w_tag_next[i];
                r_target[i] <= w_target_next[i];
                r_cnt[i]    <= w_cnt_next[i];
            end
        end
    end

    // Saturating statistics; mispredicts count even while invalidating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_lookups     <= '0;
            r_stat_hits        <= '0;
            r_stat_mispredicts <= '0;
        end else if (ce) begin
            if (bus.lookup_valid && (r_stat_lookups != STAT_MAX))
                r_stat_lookups <= r_stat_lookups + STAT_ONE;
            if (bus.lookup_valid && w_lk_hit && (r_stat_hits != STAT_MAX))
                r_stat_hits <= r_stat_hits + STAT_ONE;
            if (bus.upd_valid && bus.upd_mispredict && (r_stat_mispredicts != STAT_MAX))
                r_stat_mispredicts <= r_stat_mispredicts + STAT_ONE;
        end
    end

    assign bus.stat_lookups     = r_stat_lookups;
    assign bus.stat_hits        = r_stat_hits;
    assign bus.stat_mispredicts = r_stat_mispredicts;
endmodule

// File: doc/m_branch_target_buffer.md
Name: m_branch_target_buffer

Overview:
Parametrised branch target buffer with per-entry saturating direction counters, replacing the single-bit branch-destination memorisation used by the IF stage. IF looks it up every cycle with the fetch PC and gets a hit/taken/target prediction in the same cycle. The stage that resolves branches sends one update per resolved branch. Built-in saturating statistics counters support the contest performance measurements.

Parameters:
ENTRIES, 64, number of direct-mapped entries; power of two, >= 2; IDX_W = log2(ENTRIES)
TAG_BITS, 8, tag width; IDX_W + 2 + TAG_BITS <= 32
CNT_BITS, 2, direction counter width; >= 1
STAT_W, 32, width of statistics counters

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; when 0, no state changes (reset still acts)
lookup_valid  in  1  lookup request, used only for statistics
lookup_pc  in  32  fetch PC
pred_hit  out  1  entry valid and tag matches lookup_pc
pred_taken  out  1  pred_hit and counter MSB = 1
pred_target  out  32  stored target if pred_hit, else lookup_pc + 4
upd_valid  in  1  resolved-branch update strobe
upd_pc  in  32  PC of the resolved branch
upd_taken  in  1  actual branch outcome
upd_target  in  32  actual taken target
upd_mispredict  in  1  resolving stage's mispredict flag, used only for statistics
invalidate  in  1  clears all valid bits
stat_lookups  out  STAT_W  count of lookups
stat_hits  out  STAT_W  count of lookups that hit
stat_mispredicts  out  STAT_W  count of mispredicted updates

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+2+TAG_BITS-1:IDX_W+2]. pc[1:0] ignored.
- Each entry holds valid, tag, target[31:0] and a CNT_BITS counter. Storage is flops, not block RAM, so that reset can be asynchronous.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - all valid = 0
  - all counters = 2^(CNT_BITS-1) - 1 (weakly not-taken)
  - all targets and tags = 0
  - all stat counters = 0
  - Outputs immediately read pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4.
- Lookup is purely combinational with zero latency and has no bypass. An update in cycle N becomes visible to a lookup in cycle N+1. A same-cycle lookup of the index being updated sees the old contents.
- Update, on posedge with ce = 1, upd_valid = 1 and invalidate = 0:
  - Hit (valid and tag match): counter +1 if upd_taken, saturating at 2^CNT_BITS - 1; counter -1 if not taken, saturating at 0. If upd_taken, target <= upd_target. Tag and valid unchanged.
  - Miss and upd_taken: allocate, overwriting any aliased entry. valid <= 1, tag <= upd tag, target <= upd_target, counter <= 2^(CNT_BITS-1) (weakly taken).
  - Miss and not taken: no change.
- invalidate, on posedge with ce = 1:
  - All valid <= 0; counters and targets retained.
  - Takes priority over a simultaneous update, which is dropped.
- Statistics, on posedge with ce = 1, each counter saturating at 2^STAT_W - 1:
  - stat_lookups +1 when lookup_valid.
  - stat_hits +1 when lookup_valid and pred_hit.
  - stat_mispredicts +1 when upd_valid and upd_mispredict; counted even when invalidate is high.
- ce = 0: all state holds; combinational outputs still track lookup_pc.
- pred_target + 4 arithmetic is 32-bit and wraps: 0xFFFFFFFC -> 0x00000000.

Test Plan:
- Reset, lookup_pc = 0x40 -> pred_hit = 0, pred_taken = 0, pred_target = 0x44; all stat_* = 0.
- Update pc 0x40, taken, target 0x100 -> next cycle lookup 0x40 gives hit = 1, taken = 1, target = 0x100. Same-cycle lookup gives hit = 0.
- Three more not-taken updates of 0x40 -> counter 2 -> 1 -> 0 -> 0 (saturates). Lookup gives hit = 1, taken = 0, target still 0x100. Two taken updates restore taken = 1; four more saturate at 3.
- Aliasing: update pc 0x140, taken, target 0x200 (same index 16, tag 1 vs 0) -> lookup 0x40 misses (target 0x44); lookup 0x140 hits with target 0x200 and counter 2.
- invalidate together with an update of 0x80 -> all lookups miss; 0x80 not allocated. ce = 0 with upd_valid = 1 -> no change; stats frozen.
- Stats: 5 lookups (3 hits) and 2 mispredicted updates -> stat_lookups = 5, stat_hits = 3, stat_mispredicts = 2. rst_n pulsed low mid-cycle -> all zero and pred_hit = 0 immediately, before the next clock edge.
